background_tile_writer: RTL and testbench

BACKGROUND_TILE_WRITER -- requirements
Module: background_tile_writer

---
 rtl/background_tile_writer.sv | 150 +++++++++++++++
 tb/tb_background_tile_writer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/background_tile_writer.sv
// background_tile_writer: PIO-driven tile-map writer with whole-map clear and a one-entry pending slot.
// Rev 1.0
`default_nettype none

module background_tile_writer #(
  parameter int MAP_COLS = 40,
  parameter int MAP_ROWS = 30,
  parameter int ADDR_W   = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [4:0]        pio_cmd,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W-1:0] cursor
);

  localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(MAP_COLS * MAP_ROWS - 1);
  localparam logic [3:0]        CLEAR_CODE = 4'hF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              prev_tog_q, prev_tog_d;
  logic [ADDR_W-1:0] cursor_q, cursor_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              pend_valid_q, pend_valid_d;
  logic [3:0]        pend_code_q, pend_code_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic              req;
  logic              exec_valid;
  logic [3:0]        exec_code;

  always_comb begin
    state_d      = state_q;
    prev_tog_d   = pio_cmd[4];
    cursor_d     = cursor_q;
    clr_cnt_d    = clr_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = 1'b0;
    overflow_d   = overflow_q;
    req          = (pio_cmd[4] != prev_tog_q);
    exec_valid   = 1'b0;
    exec_code    = pend_code_q;

    case (state_q)
      IDLE: begin
        // A held request always goes first; a fresh one arriving now takes its slot.
        if (pend_valid_q) begin
          exec_valid   = 1'b1;
          exec_code    = pend_code_q;
          pend_valid_d = req;
          if (req) pend_code_d = pio_cmd[3:0];
        end else if (req) begin
          exec_valid = 1'b1;
          exec_code  = pio_cmd[3:0];
        end

        if (exec_valid) begin
          if (exec_code == CLEAR_CODE) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_q;
            wr_data_d = exec_code;
            cursor_d  = (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDR_W'(1);
          end
        end
      end

      CLEAR: begin
        wr_en_d   = 1'b1;
        busy_d    = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = 4'h0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_CELL) begin
          state_d   = IDLE;
          cursor_d  = '0;
          clr_cnt_d = '0;
        end

        if (req) begin
          if (pend_valid_q) begin
            overflow_d = 1'b1;
          end else begin
            pend_valid_d = 1'b1;
            pend_code_d  = pio_cmd[3:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      prev_tog_q   <= 1'b0;
      cursor_q     <= '0;
      clr_cnt_q    <= '0;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 4'h0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 4'h0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_tog_q   <= prev_tog_d;
      cursor_q     <= cursor_d;
      clr_cnt_q    <= clr_cnt_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign cursor   = cursor_q;

endmodule

`default_nettype wire

// File: tb/tb_background_tile_writer.sv
// tb_background_tile_writer: scoreboard bench for background_tile_writer.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_background_tile_writer;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int AW    = 11;
  localparam int CELLS = COLS * ROWS;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    pio_cmd;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          busy;
  logic          overflow;
  logic [AW-1:0] cursor;

  background_tile_writer #(
    .MAP_COLS(COLS),
    .MAP_ROWS(ROWS),
    .ADDR_W  (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .pio_cmd (pio_cmd),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .overflow(overflow),
    .cursor  (cursor)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [AW+3:0] exp_q[$];
  int exp_cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request; push its expected write(s) unless it is meant to be dropped.
  task automatic tog(input logic [3:0] code, input bit expect_it);
    @(negedge clk);
    pio_cmd = {~pio_cmd[4], code};
    if (expect_it) begin
      if (code != 4'hF) begin
        exp_q.push_back({AW'(exp_cur), code});
        exp_cur = (exp_cur + 1) % CELLS;
      end else begin
        for (int i = 0; i < CELLS; i++) exp_q.push_back({AW'(i), 4'h0});
        exp_cur = 0;
      end
    end
  endtask

  task automatic do_reset(input logic [4:0] cmd);
    @(negedge clk);
    reset_n = 1'b0;
    pio_cmd = cmd;
    exp_q.delete();
    exp_cur = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Monitor: every presented write must match the head of the scoreboard.
  initial begin
    logic [AW+3:0] e;
    forever begin
      @(negedge clk);
      if (reset_n && wr_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {16'h0, 1'b0, wr_addr, wr_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("write", {17'h0, wr_addr, wr_data}, {17'h0, e});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pio_cmd = 5'h00;
    reset_n = 1'b0;
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_cursor", cursor, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Single write
    tog(4'h5, 1);
    @(posedge clk); #1;
    chk("single_wr_en", wr_en, 1);
    chk("single_addr", wr_addr, 0);
    chk("single_data", wr_data, 5);
    chk("single_cursor", cursor, 1);
    @(posedge clk); #1;
    chk("single_wr_en_drop", wr_en, 0);
    chk("single_hold_data", wr_data, 5);

    // Cursor wrap
    do_reset(5'h00);
    for (int i = 0; i < CELLS - 1; i++) tog(4'(i % 15), 1);
    @(posedge clk); #1;
    chk("preload_cursor", cursor, CELLS - 1);
    tog(4'h3, 1);
    @(posedge clk); #1;
    chk("wrap_addr", wr_addr, CELLS - 1);
    chk("wrap_data", wr_data, 3);
    chk("wrap_cursor", cursor, 0);
    tog(4'h9, 1);
    @(posedge clk); #1;
    chk("after_wrap_addr", wr_addr, 0);
    chk("after_wrap_data", wr_data, 9);

    // Full clear
    tog(4'hF, 1);
    @(posedge clk); #1;
    chk("clr_entry_busy", busy, 0);
    chk("clr_entry_wr_en", wr_en, 0);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (busy) begin
        n++;
        if (!wr_en) chk("clr_wr_en_with_busy", wr_en, 1);
      end else break;
    end
    chk("clr_busy_cycles", n, CELLS);
    chk("clr_end_wr_en", wr_en, 0);
    chk("clr_end_cursor", cursor, 0);

    // Pending and overflow during clear
    tog(4'hF, 1);
    repeat (99) @(negedge clk);
    tog(4'h2, 1);
    repeat (99) @(negedge clk);
    tog(4'h7, 0);
    @(posedge clk); #1;
    chk("ovf_set", overflow, 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 2000);
    chk("ovf_clear_timeout", busy, 0);
    chk("pend_wr_en", wr_en, 1);
    chk("pend_addr", wr_addr, 0);
    chk("pend_data", wr_data, 2);
    repeat (3) @(posedge clk); #1;
    chk("pend_cursor", cursor, 1);
    chk("ovf_sticky", overflow, 1);
    chk("pend_queue_empty", exp_q.size(), 0);

    // Reset mid-clear
    tog(4'hF, 1);
    @(posedge clk); #1;
    repeat (500) @(posedge clk);
    #1;
    chk("midclr_busy_before", busy, 1);
    reset_n = 1'b0;
    pio_cmd = 5'h00;
    #1;
    chk("midclr_wr_en", wr_en, 0);
    chk("midclr_busy", busy, 0);
    chk("midclr_overflow", overflow, 0);
    exp_q.delete();
    exp_cur = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("midclr_idle_wr_en", wr_en, 0);
    chk("midclr_idle_busy", busy, 0);
    chk("midclr_cursor", cursor, 0);

    // Back-to-back requests
    tog(4'h1, 1);
    @(posedge clk); #1;
    chk("b2b_1_wr_en", wr_en, 1);
    chk("b2b_1_addr", wr_addr, 0);
    tog(4'h4, 1);
    @(posedge clk); #1;
    chk("b2b_2_wr_en", wr_en, 1);
    chk("b2b_2_addr", wr_addr, 1);
    chk("b2b_2_data", wr_data, 4);
    chk("b2b_cursor", cursor, 2);

    // Toggle bit already high when reset releases
    do_reset(5'h18);
    exp_q.push_back({AW'(0), 4'h8});
    exp_cur = 1;
    @(posedge clk); #1;
    chk("post_rst_req_wr_en", wr_en, 1);
    chk("post_rst_req_data", wr_data, 8);
    repeat (5) @(posedge clk); #1;
    chk("post_rst_req_cursor", cursor, 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
